aidan_medcalf_pid_controller: RTL and testbench

Single-channel 8-bit digital PID controller for a TinyTapeout-2 user slot, packed onto an 8-bit input bus and an 8-bit output bus. A host writes four configuration bytes over an SPI slave port: setpoint, Kp, Ki and Kd. While enabled, the block loops continuously:
- reads the process variable from an external SPI ADC;
- computes a clamped PID output;
- writes that output to an external SPI DAC.

---
 rtl/aidan_medcalf_pid_controller.sv | 169 ++++++++++++++++
 tb/tb_aidan_medcalf_pid_controller.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aidan_medcalf_pid_controller.sv
`timescale 1ns/1ps
// aidan_medcalf_pid_controller: 8-bit PID loop configured over an SPI slave,
// reading PV from an SPI ADC and driving OUT to an SPI DAC every 34 cycles.
//
// state   | meaning
// S_IDLE  | both chip selects high, en sampled here only
// S_READ  | ADC frame, 16 cycles, PV shifted in at end of each high phase
// S_CALC  | single-cycle PID update of I, e_prev and OUT
// S_WRITE | DAC frame, 16 cycles, OUT driven MSB first
module aidan_medcalf_pid_controller (
   input  logic [7:0] io_in,
   output logic [7:0] io_out
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_CALC = 2'd2, S_WRITE = 2'd3} state_t;

   logic w_clk, w_rst_n, w_en, w_sck, w_mosi, w_cs, w_miso, w_unused;
   assign w_clk    = io_in[0];
   assign w_rst_n  = io_in[1];
   assign w_en     = io_in[2];
   assign w_sck    = io_in[3];
   assign w_mosi   = io_in[4];
   assign w_unused = io_in[5];
   assign w_cs     = io_in[6];
   assign w_miso   = io_in[7];

   state_t     r_state, w_state_nxt;
   logic [3:0] r_cnt, w_cnt_nxt;

   logic [2:0] r_sck_sync;
   logic [1:0] r_mosi_sync, r_cs_sync;
   logic [6:0] r_shift;
   logic [2:0] r_bit_cnt;
   logic [1:0] r_idx;
   logic [7:0] r_cfg [4];
   logic       w_sck_rise;

   // r_sck_sync[2] is the delayed copy used only for edge detection
   assign w_sck_rise = r_sck_sync[1] & ~r_sck_sync[2];

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_cs_sync   <= 2'b11;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_idx       <= '0;
         for (int k = 0; k < 4; k++) r_cfg[k] <= '0;
      end else begin
         r_sck_sync  <= {r_sck_sync[1:0], w_sck};
         r_mosi_sync <= {r_mosi_sync[0], w_mosi};
         r_cs_sync   <= {r_cs_sync[0], w_cs};
         if (r_cs_sync[1]) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
         end else if (w_sck_rise) begin
            r_shift   <= {r_shift[5:0], r_mosi_sync[1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
               r_cfg[r_idx] <= {r_shift, r_mosi_sync[1]};
               r_idx        <= r_idx + 2'd1;
            end
         end
      end
   end

   logic [7:0]         r_pv, r_out;
   logic signed [11:0] r_i;
   logic signed [8:0]  r_eprev;

   logic signed [8:0]  w_e;
   logic signed [12:0] w_i_sum;
   logic signed [11:0] w_i_nxt;
   logic signed [9:0]  w_d;
   logic signed [23:0] w_kp, w_ki, w_kd, w_e_x, w_i_x, w_d_x, w_sum, w_shift;
   logic [7:0]         w_out;

   assign w_e     = $signed({1'b0, r_cfg[0]}) - $signed({1'b0, r_pv});
   assign w_i_sum = $signed({r_i[11], r_i}) + $signed({{4{w_e[8]}}, w_e});
   assign w_d     = $signed({w_e[8], w_e}) - $signed({r_eprev[8], r_eprev});

   assign w_kp  = $signed({16'd0, r_cfg[1]});
   assign w_ki  = $signed({16'd0, r_cfg[2]});
   assign w_kd  = $signed({16'd0, r_cfg[3]});
   assign w_e_x = $signed({{15{w_e[8]}}, w_e});
   assign w_i_x = $signed({{12{w_i_nxt[11]}}, w_i_nxt});
   assign w_d_x = $signed({{14{w_d[9]}}, w_d});

   assign w_sum   = (w_kp * w_e_x) + (w_ki * w_i_x) + (w_kd * w_d_x);
   assign w_shift = w_sum >>> 4;

   always_comb begin
      w_i_nxt = w_i_sum[11:0];
      if (w_i_sum[12:11] == 2'b01)      w_i_nxt = 12'sh7FF;
      else if (w_i_sum[12:11] == 2'b10) w_i_nxt = 12'sh800;
   end

   always_comb begin
      w_out = w_shift[7:0];
      if (w_shift[23])         w_out = 8'h00;
      else if (|w_shift[22:8]) w_out = 8'hFF;
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_pv    <= '0;
         r_out   <= '0;
         r_i     <= '0;
         r_eprev <= '0;
      end else begin
         // even count values are the high phase of each ADC bit
         if (r_state == S_READ && !r_cnt[0]) r_pv <= {r_pv[6:0], w_miso};
         if (r_state == S_CALC) begin
            r_i     <= w_i_nxt;
            r_eprev <= w_e;
            r_out   <= w_out;
         end
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   logic w_ctrl_clk, w_in_cs, w_out_cs, w_ctrl_mosi;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ctrl_clk  = 1'b0;
      w_in_cs     = 1'b1;
      w_out_cs    = 1'b1;
      w_ctrl_mosi = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_en) begin
               w_state_nxt = S_READ;
               w_cnt_nxt   = 4'd15;
            end
         end
         S_READ: begin
            w_in_cs    = 1'b0;
            w_ctrl_clk = ~r_cnt[0];
            if (r_cnt == 4'd0) w_state_nxt = S_CALC;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         S_CALC: begin
            w_state_nxt = S_WRITE;
            w_cnt_nxt   = 4'd15;
         end
         S_WRITE: begin
            w_out_cs    = 1'b0;
            w_ctrl_clk  = ~r_cnt[0];
            w_ctrl_mosi = r_out[r_cnt[3:1]];
            if (r_cnt == 4'd0) w_state_nxt = S_IDLE;
            else               w_cnt_nxt   = r_cnt - 4'd1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign io_out = {4'b0000, w_ctrl_mosi, w_out_cs, w_in_cs, w_ctrl_clk};
endmodule

// File: tb/tb_aidan_medcalf_pid_controller.sv
`timescale 1ns/1ps
// Bench for aidan_medcalf_pid_controller: SPI config master, ADC/DAC models,
// per-cycle protocol monitor and an integer PID reference model.
module tb_aidan_medcalf_pid_controller;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, sck = 1'b0, mosi = 1'b0, cs = 1'b1, miso = 1'b0;
   logic [7:0] io_in, io_out;
   assign io_in = {miso, cs, 1'b0, mosi, sck, en, rst_n, clk};

   aidan_medcalf_pid_controller dut (.io_in(io_in), .io_out(io_out));

   always #5 clk = ~clk;

   int n_cmp = 0, n_fail = 0, cyc = 0;
   int m_cfg [4];
   int m_i = 0, m_eprev = 0;
   logic [7:0] adc_val = 8'h00, loop_pv = 8'h00;
   int in_falls = 0, out_falls = 0, dac_count = 0;
   int fall_q [$];
   logic [7:0] dac_q [$];

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference PID in plain integer arithmetic
   function automatic int model_step(input int pv);
      int e, d, s, o;
      e   = m_cfg[0] - pv;
      m_i = m_i + e;
      if (m_i > 2047) m_i = 2047;
      else if (m_i < -2048) m_i = -2048;
      d       = e - m_eprev;
      m_eprev = e;
      s = m_cfg[1] * e + m_cfg[2] * m_i + m_cfg[3] * d;
      o = s >>> 4;
      if (o < 0) o = 0;
      else if (o > 255) o = 255;
      return o;
   endfunction

   // ADC model: presents adc_val MSB first, advancing after each falling ctrl_clk
   int a_bit = 0;
   logic a_psclk = 1'b0;
   always @(negedge clk) begin
      if (io_out[1]) a_bit = 0;
      else if (a_psclk && !io_out[0]) a_bit++;
      if (a_bit < 8) miso = adc_val[7 - a_bit];
      a_psclk = io_out[0];
   end

   // Protocol monitor and DAC capture
   logic p_in_cs = 1'b1, p_out_cs = 1'b1, p_sclk = 1'b0, out_run = 1'b0;
   int in_len = 0, out_len = 0, dac_bits = 0, last_fall = 0, exp_byte = 0;
   logic [7:0] dac_sh = 8'h00;
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         p_in_cs = 1'b1; p_out_cs = 1'b1; p_sclk = 1'b0; out_run = 1'b0;
         in_len = 0; out_len = 0; dac_bits = 0;
      end else begin
         check("reserved_bits", int'(io_out[7:4]), 0);
         if (io_out[1] && io_out[2]) begin
            check("idle_ctrl_clk", int'(io_out[0]), 0);
            check("idle_ctrl_mosi", int'(io_out[3]), 0);
         end
         if (p_in_cs && !io_out[1]) begin
            in_falls++;
            fall_q.push_back(cyc);
            last_fall = cyc;
            in_len    = 0;
            loop_pv   = adc_val;
         end
         if (!io_out[1]) in_len++;
         if (!p_in_cs && io_out[1]) check("adc_cs_len", in_len, 16);
         if (p_out_cs && !io_out[2]) begin
            out_falls++;
            check("cs_gap", cyc - last_fall, 17);
            out_len = 0; dac_bits = 0; dac_sh = 8'h00; out_run = 1'b1;
            exp_byte = model_step(int'(loop_pv));
         end
         if (!io_out[2]) begin
            out_len++;
            if (!p_sclk && io_out[0]) begin
               dac_sh = {dac_sh[6:0], io_out[3]};
               dac_bits++;
            end
         end
         if (!p_out_cs && io_out[2] && out_run) begin
            check("dac_cs_len", out_len, 16);
            check("dac_bits", dac_bits, 8);
            check("dac_vs_model", int'(dac_sh), exp_byte);
            dac_q.push_back(dac_sh);
            dac_count++;
            out_run = 1'b0;
         end
         p_in_cs  = io_out[1];
         p_out_cs = io_out[2];
         p_sclk   = io_out[0];
      end
   end

   task automatic spi_bit(input logic b);
      mosi = b;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
   endtask

   task automatic spi_frame(input logic [39:0] data, input int nbytes);
      int idx;
      logic [7:0] b;
      idx = 0;
      cs  = 1'b0;
      repeat (4) @(negedge clk);
      for (int j = 0; j < nbytes; j++) begin
         b = data[39 - 8*j -: 8];
         for (int k = 7; k >= 0; k--) spi_bit(b[k]);
         m_cfg[idx] = int'(b);
         idx = (idx + 1) % 4;
      end
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic spi_partial(input int nbits);
      cs = 1'b0;
      repeat (4) @(negedge clk);
      for (int k = 0; k < nbits; k++) spi_bit(1'b1);
      repeat (4) @(negedge clk);
      cs = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) m_cfg[k] = 0;
      m_i = 0;
      m_eprev = 0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_dac(input int target, input int limit);
      int t;
      t = 0;
      while (dac_count < target && t < limit) begin
         @(negedge clk);
         t++;
      end
   endtask

   task automatic run_one(input logic [7:0] pv, input logic [7:0] lit, input string name);
      int n0;
      adc_val = pv;
      n0 = dac_count;
      en = 1'b1;
      @(negedge clk);
      check("adc_cs_after_en", int'(io_out[1]), 0);
      en = 1'b0;
      wait_dac(n0 + 1, 100);
      check({name, "_done"}, dac_count - n0, 1);
      if (dac_count > n0) check(name, int'(dac_q[n0]), int'(lit));
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int n0, f0, o0, fq0, t;
      for (int k = 0; k < 4; k++) m_cfg[k] = 0;
      repeat (3) @(negedge clk);
      check("rst_io_out", int'(io_out), 8'h06);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_one(8'h00, 8'h00, "zero_cfg");

      spi_frame({8'h80, 8'h10, 8'h00, 8'h00, 8'h00}, 4);
      run_one(8'h40, 8'h40, "p_only");

      spi_frame({8'h20, 8'h10, 8'h00, 8'h00, 8'h90}, 5);
      run_one(8'h40, 8'h50, "fifth_byte_wraps");

      spi_partial(3);
      spi_frame({8'h80, 8'h10, 8'h00, 8'h00, 8'h00}, 4);
      run_one(8'hFF, 8'h00, "clamp_low");

      spi_frame({8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00}, 4);
      run_one(8'h00, 8'hFF, "clamp_high");

      // reset in the middle of an ADC frame
      adc_val = 8'hA5;
      en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_io", int'(io_out), 8'h06);
      do_reset();

      // integral accumulation over back-to-back loops
      spi_frame({8'h81, 8'h00, 8'h10, 8'h00, 8'h00}, 4);
      adc_val = 8'h80;
      n0 = dac_count; f0 = in_falls; fq0 = fall_q.size();
      en = 1'b1;
      t = 0;
      while (in_falls < f0 + 3 && t < 200) begin
         @(negedge clk);
         t++;
      end
      en = 1'b0;
      wait_dac(n0 + 3, 200);
      check("integral_count", dac_count - n0, 3);
      if (dac_count >= n0 + 3) begin
         check("integral_1", int'(dac_q[n0]), 1);
         check("integral_2", int'(dac_q[n0 + 1]), 2);
         check("integral_3", int'(dac_q[n0 + 2]), 3);
      end
      if (fall_q.size() >= fq0 + 3) begin
         check("period_1_2", fall_q[fq0 + 1] - fall_q[fq0], 34);
         check("period_2_3", fall_q[fq0 + 2] - fall_q[fq0 + 1], 34);
      end
      repeat (100) @(negedge clk);
      check("en_low_stops_loop", in_falls - f0, 3);

      // disabled: no chip-select activity
      f0 = in_falls; o0 = out_falls;
      repeat (200) @(negedge clk);
      check("idle_no_adc", in_falls - f0, 0);
      check("idle_no_dac", out_falls - o0, 0);

      // drop en during WRITE
      n0 = dac_count; f0 = in_falls;
      en = 1'b1;
      t = 0;
      while (io_out[2] && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("write_started", int'(io_out[2]), 0);
      repeat (5) @(negedge clk);
      en = 1'b0;
      wait_dac(n0 + 1, 60);
      check("drop_write_done", dac_count - n0, 1);
      if (dac_count > n0) check("drop_write_val", int'(dac_q[n0]), 4);
      repeat (100) @(negedge clk);
      check("drop_write_no_more", in_falls - f0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: actual timeout required finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
